design_switch_seq: RTL and testbench

Sequences a change of the active design behind the Wishbone-controlled IO multiplexer. It takes a select request from the Wishbone register decode and holds every design in reset with the shared IO pads forced to high-Z. It then switches the multiplexer select, waits for the new design's pad paths to settle, and releases only the newly selected design from reset. It sits between the Wishbone slave logic and the multiplexer, driving the multiplexer's select and the per-design reset lines.

---
 rtl/design_switch_seq.sv | 165 ++++++++++++++++
 tb/tb_design_switch_seq.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/design_switch_seq.sv
// Design-switch sequencer: isolates the IO pads, holds every design in reset, swaps the mux select,
// waits for settling, then releases only the selected design. Optional pending buffer: DSS_PENDING_REQ_EN.
module design_switch_seq #(
    parameter int NUM_DESIGNS   = 3,
    parameter int SEL_W         = 2,
    parameter int GUARD_CYCLES  = 16,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   req_valid,
    input  logic [SEL_W-1:0]       req_sel,
    output logic                   req_ready,
    output logic [SEL_W-1:0]       mux_sel,
    output logic                   io_hiz,
    output logic [NUM_DESIGNS-1:0] rst_n_designs,
    output logic                   busy,
    output logic                   active,
    output logic                   sel_err
);

    typedef enum logic [1:0] {OFF, ISOLATE, SETTLE, RUN} state_t;

    localparam int CNT_MAX = (GUARD_CYCLES > SETTLE_CYCLES) ? GUARD_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] GUARD_LOAD  = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [SEL_W-1:0] STOP_SEL    = '1;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [SEL_W-1:0] target;

    logic             idle;
    logic             accept;
    logic             legal;
    logic             launch;
    logic             reject;
    logic [SEL_W-1:0] launch_sel;

    function automatic logic [NUM_DESIGNS-1:0] one_hot(input logic [SEL_W-1:0] s);
        logic [NUM_DESIGNS-1:0] v;
        for (int i = 0; i < NUM_DESIGNS; i++) begin
            v[i] = (s == SEL_W'(i));
        end
        return v;
    endfunction

    assign idle   = (state == OFF) || (state == RUN);
    assign accept = req_valid && req_ready;
    assign legal  = (req_sel < SEL_W'(NUM_DESIGNS)) || (req_sel == STOP_SEL);

`ifdef DSS_PENDING_REQ_EN
    logic             pend_valid;
    logic [SEL_W-1:0] pend_sel;
    logic             store;

    // The buffer is only ever full during busy time or the single RUN/OFF cycle that drains it.
    assign req_ready = !pend_valid;
`else
    assign req_ready = idle;
`endif

    // NOTE: every variable gets a default before any branch so this stays pure combinational logic
    // instead of inferring a latch on the paths that do not assign it.
    always_comb begin
        launch     = 1'b0;
        launch_sel = req_sel;
        reject     = accept && !legal;
`ifdef DSS_PENDING_REQ_EN
        store      = 1'b0;
`endif
        if (idle) begin
`ifdef DSS_PENDING_REQ_EN
            if (pend_valid) begin
                launch     = 1'b1;
                launch_sel = pend_sel;
            end else
`endif
            if (accept && legal) begin
                launch = 1'b1;
            end
        end
`ifdef DSS_PENDING_REQ_EN
        else if (accept && legal) begin
            store = 1'b1;
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples the
    // pre-edge values and the order of statements below does not change behaviour.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state         <= OFF;
            cnt           <= '0;
            mux_sel       <= '0;
            io_hiz        <= 1'b1;
            rst_n_designs <= '0;
            busy          <= 1'b0;
            active        <= 1'b0;
            sel_err       <= 1'b0;
            // NOTE: the target and buffer registers are reset too; they are tiny, and a known value
            // keeps X out of the select path if a sequence is aborted and never restarted.
            target        <= '0;
`ifdef DSS_PENDING_REQ_EN
            pend_valid    <= 1'b0;
            pend_sel      <= '0;
`endif
        end else begin
            sel_err <= reject;

`ifdef DSS_PENDING_REQ_EN
            if (store) begin
                pend_valid <= 1'b1;
                pend_sel   <= req_sel;
            end else if (launch) begin
                pend_valid <= 1'b0;
            end
`endif

            if (launch) begin
                state         <= ISOLATE;
                target        <= launch_sel;
                cnt           <= GUARD_LOAD;
                io_hiz        <= 1'b1;
                rst_n_designs <= '0;
                busy          <= 1'b1;
                active        <= 1'b0;
            end else begin
                case (state)
                    ISOLATE: begin
                        if (cnt == '0) begin
                            if (target == STOP_SEL) begin
                                // Stop: pads stay isolated, mux_sel keeps the last design.
                                state <= OFF;
                                busy  <= 1'b0;
                            end else begin
                                state   <= SETTLE;
                                mux_sel <= target;
                                cnt     <= SETTLE_LOAD;
                            end
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    SETTLE: begin
                        if (cnt == '0) begin
                            state         <= RUN;
                            rst_n_designs <= one_hot(mux_sel);
                            io_hiz        <= 1'b0;
                            busy          <= 1'b0;
                            active        <= 1'b1;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_design_switch_seq.sv
// Directed self-checking bench for design_switch_seq: default instance plus a 2-design instance
// used for the illegal-select case. Expectations follow DSS_PENDING_REQ_EN when it is defined.
module tb_design_switch_seq;

    logic       clk;
    logic       rst;

    logic       req_valid;
    logic [1:0] req_sel;
    logic       req_ready;
    logic [1:0] mux_sel;
    logic       io_hiz;
    logic [2:0] rst_n_designs;
    logic       busy;
    logic       active;
    logic       sel_err;

    logic       req_valid_b;
    logic [1:0] req_sel_b;
    logic       req_ready_b;
    logic [1:0] mux_sel_b;
    logic       io_hiz_b;
    logic [1:0] rst_n_designs_b;
    logic       busy_b;
    logic       active_b;
    logic       sel_err_b;

    int errors = 0;
    int checks = 0;
    logic [1:0] cur;

    design_switch_seq dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .req_valid     (req_valid),
        .req_sel       (req_sel),
        .req_ready     (req_ready),
        .mux_sel       (mux_sel),
        .io_hiz        (io_hiz),
        .rst_n_designs (rst_n_designs),
        .busy          (busy),
        .active        (active),
        .sel_err       (sel_err)
    );

    design_switch_seq #(.NUM_DESIGNS(2)) dut_b (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .req_valid     (req_valid_b),
        .req_sel       (req_sel_b),
        .req_ready     (req_ready_b),
        .mux_sel       (mux_sel_b),
        .io_hiz        (io_hiz_b),
        .rst_n_designs (rst_n_designs_b),
        .busy          (busy_b),
        .active        (active_b),
        .sel_err       (sel_err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and land 1 time unit after the last one.
    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present a request for exactly one edge (the accept edge, T0).
    task automatic request(input logic [1:0] sel);
        req_valid = 1'b1;
        req_sel   = sel;
        cycles(1);
        req_valid = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        req_valid   = 1'b0;
        req_sel     = 2'd0;
        req_valid_b = 1'b0;
        req_sel_b   = 2'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Power-up
        check("pwr_mux_sel", mux_sel, 0);
        check("pwr_io_hiz", io_hiz, 1);
        check("pwr_rst_n", rst_n_designs, 3'b000);
        check("pwr_req_ready", req_ready, 1);
        check("pwr_active", active, 0);
        check("pwr_busy", busy, 0);
        check("pwr_sel_err", sel_err, 0);

        // Basic switch to design 2
        request(2'd2);
        check("sw_t0_io_hiz", io_hiz, 1);
        check("sw_t0_busy", busy, 1);
        check("sw_t0_ready", req_ready, 0);
        cycles(15);
        check("sw_t15_mux_sel", mux_sel, 0);
        cycles(1);
        check("sw_t16_mux_sel", mux_sel, 2);
        check("sw_t16_rst_n", rst_n_designs, 3'b000);
        cycles(7);
        check("sw_t23_active", active, 0);
        check("sw_t23_io_hiz", io_hiz, 1);
        cycles(1);
        check("sw_t24_rst_n", rst_n_designs, 3'b100);
        check("sw_t24_io_hiz", io_hiz, 0);
        check("sw_t24_active", active, 1);
        check("sw_t24_busy", busy, 0);
        check("sw_t24_ready", req_ready, 1);

        // Stop request from RUN(2)
        request(2'd3);
        check("stop_t0_io_hiz", io_hiz, 1);
        check("stop_t0_rst_n", rst_n_designs, 3'b000);
        check("stop_t0_active", active, 0);
        check("stop_t0_sel_err", sel_err, 0);
        cycles(15);
        check("stop_t15_busy", busy, 1);
        cycles(1);
        check("stop_t16_busy", busy, 0);
        check("stop_t16_io_hiz", io_hiz, 1);
        check("stop_t16_mux_sel", mux_sel, 2);
        check("stop_t16_rst_n", rst_n_designs, 3'b000);
        check("stop_t16_ready", req_ready, 1);

        // Illegal select on the 2-design instance
        req_valid_b = 1'b1;
        req_sel_b   = 2'd2;
        cycles(1);
        req_valid_b = 1'b0;
        check("ill_sel_err", sel_err_b, 1);
        check("ill_busy", busy_b, 0);
        check("ill_io_hiz", io_hiz_b, 1);
        check("ill_rst_n", rst_n_designs_b, 2'b00);
        check("ill_ready", req_ready_b, 1);
        cycles(1);
        check("ill_sel_err_end", sel_err_b, 0);
        check("ill_busy_end", busy_b, 0);

        // Reset in the middle of a switch to design 1
        request(2'd1);
        cycles(10);
        rst = 1'b1;
        #2;
        check("mid_rst_mux_sel", mux_sel, 0);
        check("mid_rst_io_hiz", io_hiz, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_rst_n", rst_n_designs, 3'b000);
        check("mid_rst_ready", req_ready, 1);
        cycles(1);
        rst = 1'b0;
        cycles(30);
        check("post_rst_active", active, 0);
        check("post_rst_busy", busy, 0);
        check("post_rst_rst_n", rst_n_designs, 3'b000);

        // Request while busy: sel=1 at T0, sel=0 at T0+5
        request(2'd1);
        cycles(4);
        req_valid = 1'b1;
        req_sel   = 2'd0;
        cycles(1);
        req_valid = 1'b0;
        check("bz_t5_busy", busy, 1);
        check("bz_t5_ready", req_ready, 0);
        cycles(19);
        check("bz_t24_rst_n", rst_n_designs, 3'b010);
        check("bz_t24_active", active, 1);
        check("bz_t24_mux_sel", mux_sel, 1);
`ifdef DSS_PENDING_REQ_EN
        check("bz_t24_ready", req_ready, 0);
        cycles(1);
        check("bz_t25_active", active, 0);
        check("bz_t25_busy", busy, 1);
        check("bz_t25_rst_n", rst_n_designs, 3'b000);
        check("bz_t25_ready", req_ready, 1);
        cycles(15);
        check("bz_t40_mux_sel", mux_sel, 1);
        cycles(1);
        check("bz_t41_mux_sel", mux_sel, 0);
        cycles(7);
        check("bz_t48_active", active, 0);
        cycles(1);
        check("bz_t49_rst_n", rst_n_designs, 3'b001);
        check("bz_t49_active", active, 1);
        cur = 2'd0;
`else
        cycles(1);
        check("bz_t25_active", active, 1);
        check("bz_t25_rst_n", rst_n_designs, 3'b010);
        cycles(24);
        check("bz_t49_active", active, 1);
        check("bz_t49_mux_sel", mux_sel, 1);
        check("bz_t49_busy", busy, 0);
        cur = 2'd1;
`endif

        // Soft reset of the running design, then a request on the SETTLE->RUN edge
        request(cur);
        check("soft_t0_rst_n", rst_n_designs, 3'b000);
        check("soft_t0_active", active, 0);
        check("soft_t0_mux_sel", mux_sel, cur);
        cycles(16);
        check("soft_t16_mux_sel", mux_sel, cur);
        check("soft_t16_rst_n", rst_n_designs, 3'b000);
        cycles(7);
        check("soft_t23_rst_n", rst_n_designs, 3'b000);
        req_valid = 1'b1;
        req_sel   = 2'd2;
        cycles(1);
        check("soft_t24_rst_n", rst_n_designs, 3'b001 << cur);
        check("soft_t24_active", active, 1);
        check("soft_t24_mux_sel", mux_sel, cur);
        cycles(1);
        req_valid = 1'b0;
        check("edge_t25_busy", busy, 1);
        check("edge_t25_io_hiz", io_hiz, 1);
        check("edge_t25_active", active, 0);
        check("edge_t25_rst_n", rst_n_designs, 3'b000);
        cycles(24);
        check("edge_t49_mux_sel", mux_sel, 2);
        check("edge_t49_rst_n", rst_n_designs, 3'b100);
        check("edge_t49_active", active, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
